// File: rtl/rans_pkg.sv
// Shared types and constants for the rANS table loader and its encoder neighbours.
package rans_pkg;

  localparam int DEFAULT_RESOLUTION   = 10;
  localparam int DEFAULT_SYMBOL_WIDTH = 8;
  localparam int NUM_SYMBOLS          = 2 ** DEFAULT_SYMBOL_WIDTH;
  localparam int PROB_SCALE           = 2 ** DEFAULT_RESOLUTION;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WRITE,
    CHECK,
    RESTART,
    DONE
  } loader_state_t;

endpackage

// File: rtl/rans_table_loader_if.sv
// Control, frequency-stream, encoder-table and status signals of the table loader.
interface rans_table_loader_if #(
  parameter int RESOLUTION   = 10,
  parameter int SYMBOL_WIDTH = 8
);

  logic                    start_i;
  logic                    freq_valid_i;
  logic                    freq_ready_o;
  logic [RESOLUTION-1:0]   freq_data_i;
  logic                    rans_ready_i;
  logic                    freq_wr_o;
  logic [SYMBOL_WIDTH-1:0] symb_o;
  logic [RESOLUTION-1:0]   freq_o;
  logic [RESOLUTION-1:0]   cum_freq_o;
  logic                    restart_o;
  logic                    busy_o;
  logic                    done_o;
  logic                    err_o;

  modport slave (
    input  start_i, freq_valid_i, freq_data_i, rans_ready_i,
    output freq_ready_o, freq_wr_o, symb_o, freq_o, cum_freq_o,
           restart_o, busy_o, done_o, err_o
  );

  modport master (
    output start_i, freq_valid_i, freq_data_i, rans_ready_i,
    input  freq_ready_o, freq_wr_o, symb_o, freq_o, cum_freq_o,
           restart_o, busy_o, done_o, err_o
  );

endinterface

// File: rtl/rans_table_loader.sv
// Streams one frequency per symbol into the encoder table with running cumulative
// sums, then restarts the encoder only if the table sums to exactly 2^RESOLUTION.
module rans_table_loader
  import rans_pkg::*;
#(
  parameter int RESOLUTION   = DEFAULT_RESOLUTION,
  parameter int SYMBOL_WIDTH = DEFAULT_SYMBOL_WIDTH
) (
  input logic clk_i,
  input logic rst_i,
  rans_table_loader_if.slave bus
);

  localparam int unsigned             SCALE     = 2 ** RESOLUTION;
  localparam logic [RESOLUTION:0]     SCALE_ACC = (RESOLUTION + 1)'(SCALE);
  localparam logic [RESOLUTION+1:0]   SCALE_EXT = (RESOLUTION + 2)'(SCALE);
  localparam logic [SYMBOL_WIDTH-1:0] LAST_SYM  = '1;

  loader_state_t           state;
  logic [SYMBOL_WIDTH-1:0] sym_cnt;
  logic [RESOLUTION:0]     acc;
  logic [RESOLUTION-1:0]   freq_q;

  logic                    freq_wr_q;
  logic [SYMBOL_WIDTH-1:0] symb_q;
  logic [RESOLUTION-1:0]   freq_out_q;
  logic [RESOLUTION-1:0]   cum_q;
  logic                    restart_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;

  logic                    hs;
  logic [RESOLUTION+1:0]   sum_next;
  logic                    ovf;

  assign bus.freq_ready_o = (state == ACCEPT) && bus.rans_ready_i;
  assign hs               = bus.freq_ready_o && bus.freq_valid_i;

  // Overflow is judged at the handshake so the write strobe can be registered.
  assign sum_next = {1'b0, acc} + {2'b00, bus.freq_data_i};
  assign ovf      = sum_next > SCALE_EXT;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      sym_cnt    <= '0;
      acc        <= '0;
      freq_q     <= '0;
      freq_wr_q  <= 1'b0;
      symb_q     <= '0;
      freq_out_q <= '0;
      cum_q      <= '0;
      restart_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      freq_wr_q <= 1'b0;
      restart_q <= 1'b0;
      done_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            sym_cnt <= '0;
            acc     <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state   <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (hs) begin
            freq_q <= bus.freq_data_i;
            state  <= WRITE;
            if (!err_q && !ovf) begin
              freq_wr_q  <= 1'b1;
              symb_q     <= sym_cnt;
              freq_out_q <= bus.freq_data_i;
              cum_q      <= acc[RESOLUTION-1:0];
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          // After an error the accumulator is frozen; the stream is still drained.
          if (!err_q) begin
            acc <= acc + {1'b0, freq_q};
          end
          sym_cnt <= sym_cnt + SYMBOL_WIDTH'(1);
          state   <= (sym_cnt == LAST_SYM) ? CHECK : ACCEPT;
        end
        CHECK: begin
          if (err_q || (acc != SCALE_ACC)) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            state <= RESTART;
          end
        end
        RESTART: begin
          if (bus.rans_ready_i) begin
            restart_q <= 1'b1;
            done_q    <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.freq_wr_o  = freq_wr_q;
  assign bus.symb_o     = symb_q;
  assign bus.freq_o     = freq_out_q;
  assign bus.cum_freq_o = cum_q;
  assign bus.restart_o  = restart_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.err_o      = err_q;

endmodule

// File: doc/rans_table_loader.md
# rans_table_loader

Sequencer that programs a complete symbol frequency table into the `rans_multi_stream` encoder and then restarts it. It sits between a frequency-count source (AXI-stream-style valid/ready) and the encoder's table-write/restart inputs. It accepts one frequency per symbol in symbol order and computes cumulative frequencies on the fly. It checks that the table sums to exactly 2^RESOLUTION, and issues `restart` only for a valid table.

## Interface
Parameters:
- RESOLUTION, 10, probability resolution in bits; a table must sum to 2^RESOLUTION
- SYMBOL_WIDTH, 8, symbol width; the table has 2^SYMBOL_WIDTH entries

Ports:
- Clock/reset: one clock; reset is asynchronous and active-high.
  - clk_i  in  1  clock
  - rst_i  in  1  asynchronous active-high reset
- Control:
  - start_i  in  1  one-cycle request to begin a table load; ignored while busy_o=1
- Frequency input stream:
  - freq_valid_i  in  1  frequency word valid
  - freq_ready_o  out  1  frequency word accepted when both valid and ready are high
  - freq_data_i  in  RESOLUTION  frequency of the next symbol, in order 0..2^SYMBOL_WIDTH-1
- Encoder side:
  - rans_ready_i  in  1  encoder ready_o; writes and restart are issued only while it is high
  - freq_wr_o  out  1  table write strobe, one cycle per symbol
  - symb_o  out  SYMBOL_WIDTH  symbol index for the write
  - freq_o  out  RESOLUTION  symbol frequency
  - cum_freq_o  out  RESOLUTION  sum of the frequencies of all lower symbols
  - restart_o  out  1  one-cycle encoder restart after a valid table
- Status:
  - busy_o  out  1  high from the cycle after start_i is accepted until return to IDLE
  - done_o  out  1  one-cycle pulse at the end of every load, valid or not
  - err_o  out  1  sticky table-sum error; cleared by the next accepted start_i

## Operation
- States:
  - IDLE: on start_i, clear sym_cnt, the accumulator and err_o, then go to ACCEPT.
  - ACCEPT: freq_ready_o = rans_ready_i. On handshake, register freq and go to WRITE.
  - WRITE: freq_wr_o=1 for exactly one cycle, unless err_o is set. Add freq to the accumulator and increment sym_cnt. If sym_cnt was the last symbol, go to CHECK; otherwise go back to ACCEPT.
  - CHECK: if acc != 2^RESOLUTION, set err_o. Go to DONE if err_o is set, otherwise to RESTART.
  - RESTART: wait for rans_ready_i, pulse restart_o, go to DONE.
  - DONE: pulse done_o, go to IDLE.
- Arithmetic:
  - Accumulator is RESOLUTION+1 bits; cum_freq_o = acc[RESOLUTION-1:0] before the add.
  - If acc + freq > 2^RESOLUTION, set err_o in the WRITE state of that symbol. That write and all later writes are suppressed.
- Error handling:
  - After an error, the block keeps accepting the remaining frequencies so the input stream stays aligned.
  - No restart_o is issued after an error.
- Zero-frequency symbols are still written (freq_o=0).
- A last symbol that brings the sum to exactly 2^RESOLUTION is legal; its cum_freq_o is at most 2^RESOLUTION-1.
- symb_o equals sym_cnt; sym_cnt wraps only after the last symbol, which is never re-entered.

## Timing
- Reset values: all outputs 0, state IDLE, accumulator 0, err_o 0.
- start_i accepted in IDLE at cycle 0 gives busy_o=1 at cycle 1. freq_ready_o can be high from cycle 1.
- Throughput is 2 cycles per symbol (ACCEPT, WRITE) with no stalls. freq_wr_o, symb_o, freq_o and cum_freq_o are registered and change together.
- With full throughput and no errors, done_o rises 2·2^SYMBOL_WIDTH + 3 cycles after start_i.
- Backpressure:
  - rans_ready_i low holds ACCEPT with freq_ready_o=0 and holds RESTART.
  - freq_valid_i low holds ACCEPT.
  - WRITE itself never stalls, because rans_ready_i was sampled at the handshake.
- start_i coinciding with done_o is ignored (the block is still busy).
- rst_i mid-load aborts immediately: no further writes and no restart. The encoder table is left partial; the next load overwrites it.

## Structure
- Shared package `rans_pkg`:
  - constants NUM_SYMBOLS = 2**SYMBOL_WIDTH and PROB_SCALE = 2**RESOLUTION
  - enum `loader_state_t` {IDLE, ACCEPT, WRITE, CHECK, RESTART, DONE}
- Single module; no sub-module is warranted.

## Test plan
All scenarios use RESOLUTION=10, SYMBOL_WIDTH=8.
- Uniform table, all freq=4 -> 256 writes with cum_freq_o = 4k for symbol k, one restart_o, done_o, err_o=0.
- Skewed table, symbol 0 = 769 and symbols 1..255 = 1 -> symbol 1 cum=769, symbol 255 cum=1023, restart_o once.
- Overflow, all freq=5 -> err_o set at symbol 204; writes only for symbols 0..203; all 256 words consumed; no restart_o; done_o pulses.
- Underflow, all freq=3 -> 256 writes, err_o at CHECK, no restart_o. A following valid start_i clears err_o.
- Backpressure: rans_ready_i low for 10 cycles at symbol 100, and freq_valid_i toggling randomly -> no write while stalled, no lost or duplicated symbol, final cum values correct.
- Reset at symbol 50 -> all outputs 0 within the reset; a following uniform load completes cleanly with err_o=0.
